// File: rtl/multi_ported_flop_lvt_pkg.sv
// Shared types and helpers for the flop-based live-value-table multi-ported memory.
// Covers the init FSM state, the LVT entry width and the flat-bus slice offsets.
package multi_ported_flop_lvt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  // One bit is still needed when there is a single write port.
  function automatic int lvt_width(input int num_w);
    return (num_w > 1) ? $clog2(num_w) : 1;
  endfunction

  function automatic int addr_lsb(input int port, input int aw);
    return port * aw;
  endfunction

  function automatic int data_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/multi_ported_flop_lvt_bank.sv
// One-write, NUM_R-read flop bank holding W x N entries; the init write takes precedence.
// Read ports are combinational and the caller supplies in-range addresses.
module multi_ported_flop_lvt_bank
  import multi_ported_flop_lvt_pkg::*;
#(
  parameter int NUM_R = 3,
  parameter int W     = 32,
  parameter int N     = 1024,
  parameter int AW    = $clog2(N)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [W-1:0]        wdata,
  input  logic                init_we,
  input  logic [AW-1:0]       init_addr,
  input  logic [W-1:0]        init_data,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R*W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int r = 0; r < NUM_R; r++) begin
      rdata[data_lsb(r, W) +: W] = mem[raddr[addr_lsb(r, AW) +: AW]];
    end
  end

endmodule

// File: rtl/multi_ported_flop_lvt.sv
// NUM_W-write / NUM_R-read memory built from one flop bank per write port plus a live-value
// table naming the bank that holds each entry's latest value, with a self-running clear engine.
module multi_ported_flop_lvt
  import multi_ported_flop_lvt_pkg::*;
#(
  parameter int           NUM_R      = 3,
  parameter int           NUM_W      = 3,
  parameter int           W          = 32,
  parameter int           N          = 1024,
  parameter bit           BYPASS     = 1'b0,
  parameter logic [W-1:0] INIT_VALUE = '0,
  parameter int           AW         = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_R-1:0]    ren,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R*W-1:0]  rdata,
  input  logic [NUM_W-1:0]    wen,
  input  logic [NUM_W*AW-1:0] waddr,
  input  logic [NUM_W*W-1:0]  wdata,
  output logic [NUM_W-1:0]    wcollide,
  input  logic                init,
  output logic                busy_w
);

  localparam int              LW        = lvt_width(NUM_W);
  localparam logic [AW:0]     N_ENTRIES = (AW+1)'(N);
  localparam logic [AW-1:0]   LAST_IDX  = AW'(N - 1);

  state_t                state;
  state_t                state_nxt;
  logic [AW-1:0]         idx;
  logic [LW-1:0]         lvt [N];
  logic [NUM_W-1:0]      we_eff;
  logic [NUM_W-1:0]      lose;
  logic [NUM_W-1:0]      init_we;
  logic [NUM_R-1:0]      rd_in_range;
  logic [NUM_R*AW-1:0]   raddr_safe;
  logic [NUM_R*W-1:0]    bank_rd [NUM_W];
  logic [NUM_R*W-1:0]    rd_val;

  // Reset lands in INIT so the clear runs by itself once rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init) state_nxt = INIT;
      INIT:    if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_w = (state == INIT);
  end

  // Out-of-range writes are dropped; a port loses if any higher-index port hits its address.
  always_comb begin
    we_eff = '0;
    lose   = '0;
    for (int p = 0; p < NUM_W; p++) begin
      we_eff[p] = wen[p] && !busy_w &&
                  ({1'b0, waddr[addr_lsb(p, AW) +: AW]} < N_ENTRIES);
    end
    for (int i = 0; i < NUM_W; i++) begin
      for (int j = i + 1; j < NUM_W; j++) begin
        if (we_eff[i] && we_eff[j] &&
            (waddr[addr_lsb(i, AW) +: AW] == waddr[addr_lsb(j, AW) +: AW])) begin
          lose[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcollide <= '0;
    end else begin
      wcollide <= lose;
    end
  end

  // Ascending port order makes the highest-index writer the last assignment, so it wins.
  always_ff @(posedge clk) begin
    if (busy_w) begin
      lvt[idx] <= '0;
    end else begin
      for (int p = 0; p < NUM_W; p++) begin
        if (we_eff[p]) begin
          lvt[waddr[addr_lsb(p, AW) +: AW]] <= LW'(p);
        end
      end
    end
  end

  always_comb begin
    init_we    = '0;
    init_we[0] = busy_w;
  end

  for (genvar b = 0; b < NUM_W; b++) begin : g_bank
    multi_ported_flop_lvt_bank #(
      .NUM_R (NUM_R),
      .W     (W),
      .N     (N),
      .AW    (AW)
    ) u_bank (
      .clk       (clk),
      .we        (we_eff[b]),
      .waddr     (waddr[b*AW +: AW]),
      .wdata     (wdata[b*W +: W]),
      .init_we   (init_we[b]),
      .init_addr (idx),
      .init_data (INIT_VALUE),
      .raddr     (raddr_safe),
      .rdata     (bank_rd[b])
    );
  end

  always_comb begin
    rd_in_range = '0;
    raddr_safe  = '0;
    for (int r = 0; r < NUM_R; r++) begin
      rd_in_range[r] = ({1'b0, raddr[addr_lsb(r, AW) +: AW]} < N_ENTRIES);
      if (rd_in_range[r]) begin
        raddr_safe[addr_lsb(r, AW) +: AW] = raddr[addr_lsb(r, AW) +: AW];
      end
    end
  end

  // Bank select compares against each legal index so a stale LVT code can never index past NUM_W.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_R; r++) begin
      if (rd_in_range[r]) begin
        for (int b = 0; b < NUM_W; b++) begin
          if (lvt[raddr_safe[addr_lsb(r, AW) +: AW]] == LW'(b)) begin
            rd_val[data_lsb(r, W) +: W] = bank_rd[b][data_lsb(r, W) +: W];
          end
        end
        if (BYPASS) begin
          for (int p = 0; p < NUM_W; p++) begin
            if (we_eff[p] &&
                (waddr[addr_lsb(p, AW) +: AW] == raddr_safe[addr_lsb(r, AW) +: AW])) begin
              rd_val[data_lsb(r, W) +: W] = wdata[data_lsb(p, W) +: W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      for (int r = 0; r < NUM_R; r++) begin
        if (ren[r]) begin
          rdata[data_lsb(r, W) +: W] <= busy_w ? '0 : rd_val[data_lsb(r, W) +: W];
        end
      end
    end
  end

endmodule
